// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  localparam int unsigned CLK_HZ = 50_000_000;

endpackage

// File: rtl/button_debounce.sv
// Synchronises a raw button and emits a one-cycle pulse on each accepted press.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Synchroniser is left out of reset so a button held through reset is
  // already visible when reset drops.
  always_ff @(posedge clk_in) begin
    sync1 <= raw;
    sync2 <= sync1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer: debounced buttons drive the FSM, outputs and lap count.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LAP_W           = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             btn_start_raw,
  input  logic             btn_lap_raw,
  output logic             stop,
  output logic             clear,
  output logic             freeze,
  output logic [LAP_W-1:0] lap_count,
  output logic [1:0]       state_o
);

  logic             start_p;
  logic             lap_p;
  sw_state_t        state;
  sw_state_t        state_nx;
  logic             clear_nx;
  logic [LAP_W-1:0] lap_nx;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk_in (clk_in),
    .reset  (reset),
    .raw    (btn_start_raw),
    .press  (start_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
    .clk_in (clk_in),
    .reset  (reset),
    .raw    (btn_lap_raw),
    .press  (lap_p)
  );

  // Start is tested first in every state, so it wins over a coincident lap.
  always_comb begin
    state_nx = state;
    clear_nx = 1'b0;
    lap_nx   = lap_count;
    unique case (state)
      IDLE: begin
        if (start_p) begin
          state_nx = RUN;
        end else if (lap_p) begin
          state_nx = IDLE;
          clear_nx = 1'b1;
          lap_nx   = '0;
        end
      end
      RUN: begin
        if (start_p) begin
          state_nx = PAUSE;
        end else if (lap_p) begin
          state_nx = LAP;
          lap_nx   = (lap_count == '1) ? lap_count : lap_count + 1'b1;
        end
      end
      LAP: begin
        if (start_p) begin
          state_nx = PAUSE;
        end else if (lap_p) begin
          state_nx = RUN;
        end
      end
      PAUSE: begin
        if (start_p) begin
          state_nx = RUN;
        end else if (lap_p) begin
          state_nx = IDLE;
          clear_nx = 1'b1;
          lap_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge as it.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= IDLE;
      stop      <= 1'b1;
      clear     <= 1'b0;
      freeze    <= 1'b0;
      lap_count <= '0;
    end else begin
      state     <= state_nx;
      stop      <= !((state_nx == RUN) || (state_nx == LAP));
      clear     <= clear_nx;
      freeze    <= (state_nx == LAP);
      lap_count <= lap_nx;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed table-driven bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, LAP_W=2.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start_raw = 1'b0;
  logic       btn_lap_raw = 1'b0;
  logic       stop;
  logic       clear;
  logic       freeze;
  logic [1:0] lap_count;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_fail = 0;
  int clear_cycles = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .LAP_W(2)) u_dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .btn_start_raw (btn_start_raw),
    .btn_lap_raw   (btn_lap_raw),
    .stop          (stop),
    .clear         (clear),
    .freeze        (freeze),
    .lap_count     (lap_count),
    .state_o       (state_o)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (clear === 1'b1) clear_cycles++;

  typedef struct {
    logic      s;
    logic      l;
    sw_state_t st;
    logic      stp;
    logic      frz;
    logic [1:0] lc;
    int        clears;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_in);
  endtask

  task automatic check_all(input string tag, input sw_state_t st, input logic stp,
                           input logic frz, input logic [1:0] lc);
    check({tag, ".state"}, int'(state_o), int'(st));
    check({tag, ".stop"}, int'(stop), int'(stp));
    check({tag, ".freeze"}, int'(freeze), int'(frz));
    check({tag, ".lap_count"}, int'(lap_count), int'(lc));
  endtask

  initial begin
    int base;
    int hit;

    vecs[0]  = '{1'b0, 1'b1, LAP,   1'b0, 1'b1, 2'd1, 0};
    vecs[1]  = '{1'b0, 1'b1, RUN,   1'b0, 1'b0, 2'd1, 0};
    vecs[2]  = '{1'b0, 1'b1, LAP,   1'b0, 1'b1, 2'd2, 0};
    vecs[3]  = '{1'b0, 1'b1, RUN,   1'b0, 1'b0, 2'd2, 0};
    vecs[4]  = '{1'b0, 1'b1, LAP,   1'b0, 1'b1, 2'd3, 0};
    vecs[5]  = '{1'b0, 1'b1, RUN,   1'b0, 1'b0, 2'd3, 0};
    vecs[6]  = '{1'b0, 1'b1, LAP,   1'b0, 1'b1, 2'd3, 0};
    vecs[7]  = '{1'b1, 1'b0, PAUSE, 1'b1, 1'b0, 2'd3, 0};
    vecs[8]  = '{1'b1, 1'b0, RUN,   1'b0, 1'b0, 2'd3, 0};
    vecs[9]  = '{1'b1, 1'b1, PAUSE, 1'b1, 1'b0, 2'd3, 0};
    vecs[10] = '{1'b0, 1'b1, IDLE,  1'b1, 1'b0, 2'd0, 1};
    vecs[11] = '{1'b0, 1'b1, IDLE,  1'b1, 1'b0, 2'd0, 1};
    vecs[12] = '{1'b1, 1'b0, RUN,   1'b0, 1'b0, 2'd0, 0};
    vecs[13] = '{1'b0, 1'b1, LAP,   1'b0, 1'b1, 2'd1, 0};

    // Reset, then idle.
    cycles(3);
    #1 reset = 1'b0;
    cycles(20);
    @(negedge clk_in);
    check_all("reset_idle", IDLE, 1'b1, 1'b0, 2'd0);
    check("reset_idle.clear_cycles", clear_cycles, 0);

    // Start press with exact latency: stop falls after the 7th edge.
    @(posedge clk_in);
    #1 btn_start_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check($sformatf("start_latency.stop@%0d", k), int'(stop), (k < 7) ? 1 : 0);
    end
    cycles(3);
    #1 btn_start_raw = 1'b0;
    cycles(12);
    @(negedge clk_in);
    check_all("start_once", RUN, 1'b0, 1'b0, 2'd0);

    // Three-cycle glitch is rejected.
    @(posedge clk_in);
    #1 btn_start_raw = 1'b1;
    cycles(3);
    #1 btn_start_raw = 1'b0;
    cycles(12);
    @(negedge clk_in);
    check_all("glitch", RUN, 1'b0, 1'b0, 2'd0);

    for (int v = 0; v < 14; v++) begin
      base = clear_cycles;
      @(posedge clk_in);
      #1;
      btn_start_raw = vecs[v].s;
      btn_lap_raw   = vecs[v].l;
      cycles(8);
      #1;
      btn_start_raw = 1'b0;
      btn_lap_raw   = 1'b0;
      cycles(10);
      @(negedge clk_in);
      check_all($sformatf("vec%0d", v), vecs[v].st, vecs[v].stp, vecs[v].frz, vecs[v].lc);
      check($sformatf("vec%0d.clear_cycles", v), clear_cycles - base, vecs[v].clears);
    end

    // Reset mid-debounce in LAP with start held through reset.
    @(posedge clk_in);
    #1;
    btn_start_raw = 1'b1;
    btn_lap_raw   = 1'b1;
    cycles(3);
    #1 reset = 1'b1;
    base = clear_cycles;
    @(posedge clk_in);
    @(negedge clk_in);
    check_all("mid_reset", IDLE, 1'b1, 1'b0, 2'd0);
    check("mid_reset.clear", int'(clear), 0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    btn_lap_raw = 1'b0;
    hit = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (stop == 1'b0) begin
        hit = k;
        break;
      end
    end
    check("held_after_reset.latency", hit, 5);
    check("held_after_reset.clear_cycles", clear_cycles - base, 0);
    cycles(10);
    #1 btn_start_raw = 1'b0;
    cycles(12);
    @(negedge clk_in);
    check_all("held_once", RUN, 1'b0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
